// File: rtl/video_blit_pkg.sv
// Shared types and widths for the picture-ROM blit reader.
package video_blit_pkg;

    localparam int ABP_W     = 13;
    localparam int VW_ADDR_W = 16;
    localparam int DIM_W     = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        NEXT  = 3'd4,
        FIN   = 3'd5
    } blit_state_t;

    function automatic logic [15:0] pack_planes(input logic [3:0] z, input logic [3:0] r,
                                                input logic [3:0] g, input logic [3:0] b);
        return {z, r, g, b};
    endfunction

endpackage

// File: rtl/video_picture_blit_reader_if.sv
// Control, picture-ROM and video-RAM write signals of the blit reader.
// Handshake: a VRAM write transfers on a clock edge where VW_VALID and VW_READY are both high;
// while VW_VALID is high and VW_READY low, VW_ADDR/VW_DATA/VW_VALID hold stable.
interface video_picture_blit_reader_if;
    import video_blit_pkg::*;

    logic                 START;
    logic [ABP_W-1:0]     SRC_ADDR;
    logic [VW_ADDR_W-1:0] DST_ADDR;
    logic [DIM_W-1:0]     WIDTH;
    logic [DIM_W-1:0]     HEIGHT;
    logic                 BUSY;
    logic                 DONE;
    logic [ABP_W-1:0]     ABP;
    logic [3:0]           DPZ;
    logic [3:0]           DPR;
    logic [3:0]           DPG;
    logic [3:0]           DPB;
    logic [VW_ADDR_W-1:0] VW_ADDR;
    logic [15:0]          VW_DATA;
    logic                 VW_VALID;
    logic                 VW_READY;

    // master: the blit reader itself; slave: CPU registers, ROM and VRAM around it
    modport master (
        input  START, SRC_ADDR, DST_ADDR, WIDTH, HEIGHT,
        output BUSY, DONE,
        output ABP,
        input  DPZ, DPR, DPG, DPB,
        output VW_ADDR, VW_DATA, VW_VALID,
        input  VW_READY
    );

    modport slave (
        output START, SRC_ADDR, DST_ADDR, WIDTH, HEIGHT,
        input  BUSY, DONE,
        input  ABP,
        output DPZ, DPR, DPG, DPB,
        input  VW_ADDR, VW_DATA, VW_VALID,
        output VW_READY
    );

endinterface

// File: rtl/video_blit_addr_gen.sv
// Source pointer, column/row counters and destination row base for one blit rectangle.
module video_blit_addr_gen
    import video_blit_pkg::*;
#(
    parameter int DST_STRIDE = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_al_i,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic [ABP_W-1:0]     src_addr_i,
    input  logic [VW_ADDR_W-1:0] dst_addr_i,
    input  logic [DIM_W-1:0]     width_i,
    input  logic [DIM_W-1:0]     height_i,
    output logic [ABP_W-1:0]     src_ptr_o,
    output logic [VW_ADDR_W-1:0] dst_addr_o,
    output logic                 blit_last_o
);

    logic [ABP_W-1:0]     src_q,    src_d;
    logic [DIM_W-1:0]     col_q,    col_d;
    logic [DIM_W-1:0]     row_q,    row_d;
    logic [VW_ADDR_W-1:0] base_q,   base_d;
    logic [DIM_W-1:0]     width_q,  width_d;
    logic [DIM_W-1:0]     height_q, height_d;
    logic                 last_col;
    logic                 last_row;

    assign last_col    = (col_q == width_q - 8'd1);
    assign last_row    = (row_q == height_q - 8'd1);
    assign blit_last_o = last_col && last_row;
    assign src_ptr_o   = src_q;
    assign dst_addr_o  = base_q + {8'd0, col_q};

    always_comb begin
        src_d    = src_q;
        col_d    = col_q;
        row_d    = row_q;
        base_d   = base_q;
        width_d  = width_q;
        height_d = height_q;
        if (load_i) begin
            src_d    = src_addr_i;
            col_d    = '0;
            row_d    = '0;
            base_d   = dst_addr_i;
            width_d  = width_i;
            height_d = height_i;
        end else if (step_i) begin
            // all pointers wrap naturally at their register width
            src_d = src_q + 13'd1;
            if (last_col) begin
                col_d  = '0;
                row_d  = row_q + 8'd1;
                base_d = base_q + 16'(DST_STRIDE);
            end else begin
                col_d = col_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_al_i) begin
            src_q    <= '0;
            col_q    <= '0;
            row_q    <= '0;
            base_q   <= '0;
            width_q  <= '0;
            height_q <= '0;
        end else begin
            src_q    <= src_d;
            col_q    <= col_d;
            row_q    <= row_d;
            base_q   <= base_d;
            width_q  <= width_d;
            height_q <= height_d;
        end
    end

endmodule

// File: rtl/video_picture_blit_reader.sv
// Blit reader: fetches picture-ROM words and streams them as a WIDTH x HEIGHT rectangle into VRAM.
// Define VIDEO_BLIT_TRANSPARENT_EN to skip (not write) captured words equal to 16'h0000.
module video_picture_blit_reader
    import video_blit_pkg::*;
#(
    parameter int ROM_LAT    = 1,   // cycles from ABP change to valid DP* data, 1..3
    parameter int DST_STRIDE = 256
) (
    input  logic                        CLK,
    input  logic                        RST_AL,
    video_picture_blit_reader_if.master bus,
    output blit_state_t                 state_dbg_o
);

`ifdef VIDEO_BLIT_TRANSPARENT_EN
    localparam bit SKIP_ZERO = 1'b1;
`else
    localparam bit SKIP_ZERO = 1'b0;
`endif

    blit_state_t          state_q;
    logic                 busy_q;
    logic                 done_q;
    logic [ABP_W-1:0]     abp_q;
    logic [VW_ADDR_W-1:0] vw_addr_q;
    logic [15:0]          vw_data_q;
    logic                 vw_valid_q;
    logic [1:0]           lat_cnt_q;

    logic                 load;
    logic                 step;
    logic [ABP_W-1:0]     src_ptr;
    logic [VW_ADDR_W-1:0] dst_addr;
    logic                 blit_last;
    logic [15:0]          rom_word;

    assign rom_word = pack_planes(bus.DPZ, bus.DPR, bus.DPG, bus.DPB);
    assign load     = (state_q == IDLE) && bus.START;
    assign step     = (state_q == NEXT);

    video_blit_addr_gen #(
        .DST_STRIDE(DST_STRIDE)
    ) u_addr_gen (
        .clk_i      (CLK),
        .rst_al_i   (RST_AL),
        .load_i     (load),
        .step_i     (step),
        .src_addr_i (bus.SRC_ADDR),
        .dst_addr_i (bus.DST_ADDR),
        .width_i    (bus.WIDTH),
        .height_i   (bus.HEIGHT),
        .src_ptr_o  (src_ptr),
        .dst_addr_o (dst_addr),
        .blit_last_o(blit_last)
    );

    always_ff @(posedge CLK) begin
        if (!RST_AL) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            abp_q      <= '0;
            vw_addr_q  <= '0;
            vw_data_q  <= '0;
            vw_valid_q <= 1'b0;
            lat_cnt_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.START) begin
                        busy_q  <= 1'b1;
                        state_q <= (bus.WIDTH == '0 || bus.HEIGHT == '0) ? FIN : FETCH;
                    end
                end
                FETCH: begin
                    abp_q     <= src_ptr;
                    lat_cnt_q <= 2'(ROM_LAT);
                    state_q   <= WAIT;
                end
                WAIT: begin
                    lat_cnt_q <= lat_cnt_q - 2'd1;
                    // last latency cycle: DP* now reflects ABP
                    if (lat_cnt_q == 2'd1) begin
                        if (SKIP_ZERO && rom_word == 16'h0000) begin
                            state_q <= NEXT;
                        end else begin
                            vw_addr_q  <= dst_addr;
                            vw_data_q  <= rom_word;
                            vw_valid_q <= 1'b1;
                            state_q    <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (bus.VW_READY) begin
                        vw_valid_q <= 1'b0;
                        state_q    <= NEXT;
                    end
                end
                NEXT: begin
                    state_q <= blit_last ? FIN : FETCH;
                end
                FIN: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.BUSY     = busy_q;
    assign bus.DONE     = done_q;
    assign bus.ABP      = abp_q;
    assign bus.VW_ADDR  = vw_addr_q;
    assign bus.VW_DATA  = vw_data_q;
    assign bus.VW_VALID = vw_valid_q;
    assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_video_picture_blit_reader.sv
// Directed bench for the picture-ROM blit reader: combinational ROM model (ROM_LAT=1), write scoreboard.
module tb_video_picture_blit_reader;
    import video_blit_pkg::*;

    logic        clk;
    logic        rst_al;
    blit_state_t state_dbg;
    logic        rom_mode;
    logic [15:0] rom_word;

    int          n_checks;
    int          n_errors;
    int          wr_cnt;
    int          done_cnt;
    logic [31:0] exp_q[$];
    logic [31:0] exp_w;

    video_picture_blit_reader_if bus ();

    video_picture_blit_reader #(
        .ROM_LAT   (1),
        .DST_STRIDE(256)
    ) dut (
        .CLK        (clk),
        .RST_AL     (rst_al),
        .bus        (bus),
        .state_dbg_o(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ROM: mode 0 returns the address as data; mode 1 holds a small sprite with a zero word
    always_comb begin
        rom_word = {3'b000, bus.ABP};
        if (rom_mode) begin
            case (bus.ABP)
                13'h0010: rom_word = 16'h1234;
                13'h0011: rom_word = 16'h0000;
                13'h0012: rom_word = 16'h5678;
                default:  rom_word = 16'hDEAD;
            endcase
        end
    end
    assign bus.DPZ = rom_word[15:12];
    assign bus.DPR = rom_word[11:8];
    assign bus.DPG = rom_word[7:4];
    assign bus.DPB = rom_word[3:0];

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every accepted VRAM write must match the head of exp_q
    always @(negedge clk) begin
        if (bus.VW_VALID && bus.VW_READY) begin
            wr_cnt++;
            check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_w = exp_q.pop_front();
                check("wr_addr_data", {bus.VW_ADDR, bus.VW_DATA}, exp_w);
            end
        end
        if (bus.DONE) done_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic push_wr(input logic [15:0] addr, input logic [15:0] data);
        exp_q.push_back({addr, data});
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"},  32'(bus.BUSY),     32'd0);
        check({tag, "_done"},  32'(bus.DONE),     32'd0);
        check({tag, "_abp"},   32'(bus.ABP),      32'd0);
        check({tag, "_vwa"},   32'(bus.VW_ADDR),  32'd0);
        check({tag, "_vwd"},   32'(bus.VW_DATA),  32'd0);
        check({tag, "_vwv"},   32'(bus.VW_VALID), 32'd0);
        check({tag, "_state"}, 32'(state_dbg),    32'(IDLE));
    endtask

    // Pulses START, scrambles inputs after acceptance, fires a stray START mid-blit,
    // and checks DONE latency (cycles from the START cycle), the pulse shape and the write count.
    task automatic run_blit(input string name, input logic [12:0] src, input logic [15:0] dst,
                            input logic [7:0] w, input logic [7:0] h, input int exp_cycles);
        int cycles;
        int done_before;
        done_before = done_cnt;
        @(posedge clk); #1;
        bus.START    = 1'b1;
        bus.SRC_ADDR = src;
        bus.DST_ADDR = dst;
        bus.WIDTH    = w;
        bus.HEIGHT   = h;
        @(posedge clk); #1;
        bus.START    = 1'b0;
        bus.SRC_ADDR = 13'($urandom);
        bus.DST_ADDR = 16'($urandom);
        bus.WIDTH    = 8'($urandom_range(1, 255));
        bus.HEIGHT   = 8'($urandom_range(1, 255));
        cycles = 1;
        @(negedge clk);
        check({name, "_busy_start"}, 32'(bus.BUSY), 32'd1);
        while (!bus.DONE && cycles < 300) begin
            @(posedge clk); #1;
            cycles++;
            bus.START = (cycles == 3);
            @(negedge clk);
        end
        bus.START = 1'b0;
        check({name, "_done_seen"}, 32'(bus.DONE), 32'd1);
        check({name, "_done_lat"}, 32'(cycles), 32'(exp_cycles));
        @(posedge clk); #1;
        @(negedge clk);
        check({name, "_busy_after"}, 32'(bus.BUSY), 32'd0);
        check({name, "_done_pulse"}, 32'(bus.DONE), 32'd0);
        check({name, "_done_cnt"}, 32'(done_cnt - done_before), 32'd1);
        check({name, "_all_writes"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Holds VW_READY low so that the second write waits 4 cycles with VW_VALID high.
    task automatic stall_second_write();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.VW_VALID && bus.VW_READY) && n < 100);
        @(posedge clk); #1;
        bus.VW_READY = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.VW_VALID && n < 100);
        check("stall_valid_seen", 32'(bus.VW_VALID), 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (i != 0) @(negedge clk);
            check("stall_addr",  32'(bus.VW_ADDR),  32'h1001);
            check("stall_data",  32'(bus.VW_DATA),  32'h0041);
            check("stall_valid", 32'(bus.VW_VALID), 32'd1);
        end
        @(posedge clk); #1;
        bus.VW_READY = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int wr_before;
        int done_before;
        n_checks     = 0;
        n_errors     = 0;
        wr_cnt       = 0;
        done_cnt     = 0;
        rom_mode     = 1'b0;
        rst_al       = 1'b0;
        bus.START    = 1'b0;
        bus.SRC_ADDR = '0;
        bus.DST_ADDR = '0;
        bus.WIDTH    = '0;
        bus.HEIGHT   = '0;
        bus.VW_READY = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("por");
        @(posedge clk); #1;
        rst_al = 1'b1;

        // 2x2 rectangle, ROM word = address
        push_wr(16'h2000, 16'h0100);
        push_wr(16'h2001, 16'h0101);
        push_wr(16'h2100, 16'h0102);
        push_wr(16'h2101, 16'h0103);
        run_blit("basic", 13'h0100, 16'h2000, 8'd2, 8'd2, 18);
        check("abp_hold_basic", 32'(bus.ABP), 32'h0103);

        // single column: every word ends a row
        push_wr(16'h0010, 16'h0300);
        push_wr(16'h0110, 16'h0301);
        push_wr(16'h0210, 16'h0302);
        run_blit("column", 13'h0300, 16'h0010, 8'd1, 8'd3, 14);

        // empty rectangles: no writes, DONE two cycles after START
        wr_before = wr_cnt;
        run_blit("w0", 13'h0123, 16'h4000, 8'd0, 8'd5, 2);
        run_blit("h0", 13'h0123, 16'h4000, 8'd3, 8'd0, 2);
        check("zero_dim_writes", 32'(wr_cnt - wr_before), 32'd0);

        // back-pressure on the second write
        wr_before = wr_cnt;
        push_wr(16'h1000, 16'h0040);
        push_wr(16'h1001, 16'h0041);
        push_wr(16'h1002, 16'h0042);
        push_wr(16'h1003, 16'h0043);
        fork
            run_blit("stall", 13'h0040, 16'h1000, 8'd4, 8'd1, 22);
            stall_second_write();
        join
        check("stall_writes", 32'(wr_cnt - wr_before), 32'd4);

        // source and destination wrap
        push_wr(16'hFF00, 16'h1FFF);
`ifdef VIDEO_BLIT_TRANSPARENT_EN
        push_wr(16'h0000, 16'h0001);
        push_wr(16'h0001, 16'h0002);
        run_blit("wrap", 13'h1FFF, 16'hFF00, 8'd2, 8'd2, 17);
`else
        push_wr(16'hFF01, 16'h0000);
        push_wr(16'h0000, 16'h0001);
        push_wr(16'h0001, 16'h0002);
        run_blit("wrap", 13'h1FFF, 16'hFF00, 8'd2, 8'd2, 18);
`endif
        check("abp_hold_wrap", 32'(bus.ABP), 32'h0002);

        // reset during WAIT of the third word
        done_before = done_cnt;
        push_wr(16'h3000, 16'h0200);
        push_wr(16'h3001, 16'h0201);
        @(posedge clk); #1;
        bus.START    = 1'b1;
        bus.SRC_ADDR = 13'h0200;
        bus.DST_ADDR = 16'h3000;
        bus.WIDTH    = 8'd4;
        bus.HEIGHT   = 8'd1;
        @(posedge clk); #1;
        bus.START = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst_al = 1'b0;
        @(negedge clk);
        check("mid_state_wait", 32'(state_dbg), 32'(WAIT));
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_vals("mid");
        @(posedge clk); #1;
        rst_al = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("mid_no_done", 32'(done_cnt - done_before), 32'd0);
        check("mid_writes", 32'(exp_q.size()), 32'd0);
        check("mid_idle", 32'(state_dbg), 32'(IDLE));

        // restart after abort
        push_wr(16'h3000, 16'h0200);
        push_wr(16'h3001, 16'h0201);
        push_wr(16'h3002, 16'h0202);
        push_wr(16'h3003, 16'h0203);
        run_blit("restart", 13'h0200, 16'h3000, 8'd4, 8'd1, 18);

        // sprite containing a zero word
        rom_mode = 1'b1;
        push_wr(16'h0500, 16'h1234);
`ifdef VIDEO_BLIT_TRANSPARENT_EN
        push_wr(16'h0502, 16'h5678);
        run_blit("sprite", 13'h0010, 16'h0500, 8'd3, 8'd1, 13);
`else
        push_wr(16'h0501, 16'h0000);
        push_wr(16'h0502, 16'h5678);
        run_blit("sprite", 13'h0010, 16'h0500, 8'd3, 8'd1, 14);
`endif
        rom_mode = 1'b0;

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
